bitstream_aligner: RTL and testbench
====================================

BITSTREAM_ALIGNER -- requirements
Module: bitstream_aligner

Interface
REQ-001 SHALL have parameter LANES, default 4: number of independent reference/IOB lane pairs.
REQ-002 SHALL have parameter MAX_DELAY, default 32 (power of two, 2..256): reference delay-line depth; DW = log2(MAX_DELAY).
REQ-003 SHALL have parameter ERROR_COUNT, default 8: mismatches that trigger a delay step or loss of lock.
REQ-004 SHALL have parameter LOCK_COUNT, default 64: consecutive matches that declare lock.
REQ-005 SHALL have parameter ERROR_HOLD, default 2500000: minimum O_ERROR pulse length in cycles (fits 25 bits).
REQ-006 SHALL have port CLK  input  1  single clock; all logic on posedge.
REQ-007 SHALL have port RST_N  input  1  synchronous, active-low reset, sampled on posedge CLK.
REQ-008 SHALL have port I_DAT_REF  input  LANES  reference bitstream, bit i = lane i.
REQ-009 SHALL have port I_DAT_IOB  input  LANES  bitstream under test, bit i = lane i.
REQ-010 SHALL have port I_CLR  input  1  synchronous clear of O_ERR_CNT and O_NOLOCK, all lanes.
REQ-011 SHALL have port O_LOCKED  output  LANES  lane in LOCKED state.
REQ-012 SHALL have port O_DELAY  output  LANES*DW  current reference delay per lane, lane i at [i*DW +: DW].
REQ-013 SHALL have port O_ERROR  output  LANES  stretched mismatch indicator per lane.
REQ-014 SHALL have port O_ERR_CNT  output  LANES*16  per-lane saturating mismatch count while LOCKED, lane i at [i*16 +: 16].
REQ-015 SHALL have port O_NOLOCK  output  LANES  sticky: full delay sweep completed without lock.

Function
REQ-016 SHALL register both inputs through 3 flip-flop stages per lane; comparison uses stage-3 outputs.
REQ-017 SHALL shift each lane's stage-3 reference bit into a MAX_DELAY-deep shift register every cycle; selected bit = sreg[O_DELAY lane]; delay 0 = stage-3 ref directly delayed by one register.
REQ-018 SHALL compare the selected reference bit against the IOB stage-3 bit delayed by one register, so delay 0 aligns equal-latency streams; mismatch = XOR.
REQ-019 SHALL keep per lane: err_cnt (saturating at ERROR_COUNT), ok_cnt (saturating at LOCK_COUNT, cleared on any mismatch).
REQ-020 SHALL implement per-lane states HUNT, SHIFT, LOCKED; reset state HUNT.
REQ-021 HUNT: err_cnt reaching ERROR_COUNT -> SHIFT; ok_cnt reaching LOCK_COUNT -> LOCKED; both same cycle -> SHIFT.
REQ-022 SHIFT (exactly 1 cycle): delay <= delay+1 modulo MAX_DELAY, counters cleared, -> HUNT; mismatches in SHIFT not counted.
REQ-023 On delay wrap MAX_DELAY-1 -> 0 with no lock since last reset/I_CLR/lock loss, O_NOLOCK lane SHALL set and stay set until I_CLR or entry to LOCKED.
REQ-024 LOCKED: err_cnt reaching ERROR_COUNT -> HUNT with delay unchanged, counters cleared; ok_cnt reaching LOCK_COUNT clears err_cnt and ok_cnt (sporadic errors tolerated).
REQ-025 Entry to LOCKED SHALL clear counters; O_LOCKED asserts the cycle after the LOCK_COUNT-th consecutive match.
REQ-026 O_ERR_CNT lane SHALL increment by 1 per mismatch while LOCKED, saturate at 16'hFFFF, not wrap.
REQ-027 O_ERROR lane SHALL assert the cycle after any mismatch (any state) and stay high ERROR_HOLD cycles after the last mismatch (retriggerable).
REQ-028 I_CLR SHALL take priority over a simultaneous increment of O_ERR_CNT (result 0) and over a simultaneous O_NOLOCK set (result 0).
REQ-029 Lanes SHALL be fully independent; activity on one lane never alters another lane's state.

Reset
REQ-030 While RST_N=0 at a posedge: state HUNT, delay 0, counters 0, O_LOCKED 0, O_DELAY 0, O_ERROR 0, O_ERR_CNT 0, O_NOLOCK 0; synchroniser and delay-line contents unspecified.
REQ-031 Reset mid-lock or mid-SHIFT SHALL return to reset values on the next edge; comparison results during the first MAX_DELAY+4 cycles after reset release are counted normally.

Verification
REQ-032 PRBS7 on lane 0, IOB = REF delayed 5 cycles, LOCK_COUNT=64 -> O_DELAY[0]=5, O_LOCKED[0]=1, O_NOLOCK[0]=0, other lanes independent.
REQ-033 Locked lane, inject 7 isolated bit errors spaced >64 cycles -> stays LOCKED, O_ERR_CNT=7, O_ERROR pulses each >= ERROR_HOLD.
REQ-034 Locked lane, inject 8 consecutive errors -> O_LOCKED drops after 8th, delay unchanged, relock at same delay.
REQ-035 IOB = inverted REF (never matches), MAX_DELAY=8 -> delay sweeps 0..7, O_NOLOCK sets at wrap to 0; I_CLR -> O_NOLOCK=0, sweep continues.
REQ-036 Assert RST_N=0 for one cycle while locked at delay 5 -> all outputs zero next cycle, relock at 5.
REQ-037 Force O_ERR_CNT to 16'hFFFF via continuous errors with ERROR_COUNT large -> holds 16'hFFFF; I_CLR coincident with error -> 0.

Source files
------------

// File: rtl/bitstream_aligner_if.sv
// Purpose: bundles the per-lane data inputs, the clear strobe and all aligner status outputs.
// Latency: none, this is wiring only.
// Backpressure: none, both bitstreams are free-running and cannot be stalled.
interface bitstream_aligner_if #(
  parameter int LANES = 4,
  parameter int DW    = 5
);
  logic [LANES-1:0]    I_DAT_REF;
  logic [LANES-1:0]    I_DAT_IOB;
  logic                I_CLR;
  logic [LANES-1:0]    O_LOCKED;
  logic [LANES*DW-1:0] O_DELAY;
  logic [LANES-1:0]    O_ERROR;
  logic [LANES*16-1:0] O_ERR_CNT;
  logic [LANES-1:0]    O_NOLOCK;

  // Stimulus side: drives the streams and the clear strobe, observes the status.
  modport master (
    output I_DAT_REF, I_DAT_IOB, I_CLR,
    input  O_LOCKED, O_DELAY, O_ERROR, O_ERR_CNT, O_NOLOCK
  );

  // Aligner side.
  modport slave (
    input  I_DAT_REF, I_DAT_IOB, I_CLR,
    output O_LOCKED, O_DELAY, O_ERROR, O_ERR_CNT, O_NOLOCK
  );
endinterface

// File: rtl/bitstream_aligner.sv
// Purpose: per lane, sweeps a reference delay line until it lines up with the IOB stream, then monitors errors.
// Latency: a bit error shows on O_ERROR 5 cycles after it enters I_DAT_IOB (3 sync stages, 1 align stage, 1 status register).
// Backpressure: none; both streams are sampled every cycle and the design never stalls.
module bitstream_aligner #(
  parameter int LANES       = 4,
  parameter int MAX_DELAY   = 32,
  parameter int ERROR_COUNT = 8,
  parameter int LOCK_COUNT  = 64,
  parameter int ERROR_HOLD  = 2500000
) (
  input  logic              CLK,
  input  logic              RST_N,
  bitstream_aligner_if.slave bus
);

  localparam int DW = $clog2(MAX_DELAY);
  localparam int EW = $clog2(ERROR_COUNT + 1);
  localparam int OW = $clog2(LOCK_COUNT + 1);
  localparam int HW = $clog2(ERROR_HOLD + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SHIFT  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // Per-lane status, packed onto the interface buses below.
  logic          lane_locked [LANES];
  logic [DW-1:0] lane_delay  [LANES];
  logic          lane_error  [LANES];
  logic [15:0]   lane_ecnt   [LANES];
  logic          lane_nolock [LANES];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [2:0]           ref_sync_q;
    logic [2:0]           iob_sync_q;
    logic [MAX_DELAY-1:0] dline_q;
    logic                 iob_dly_q;
    logic                 mism;

    state_e        state_q,  state_d;
    logic [DW-1:0] delay_q,  delay_d;
    logic [EW-1:0] err_q,    err_d;
    logic [OW-1:0] ok_q,     ok_d;
    logic          nolock_q, nolock_d;
    logic [15:0]   ecnt_q,   ecnt_d;
    logic [HW-1:0] hold_q,   hold_d;

    // Input synchronisers, reference delay line and the matching IOB stage; contents need no reset.
    always_ff @(posedge CLK) begin
      ref_sync_q <= {ref_sync_q[1:0], bus.I_DAT_REF[l]};
      iob_sync_q <= {iob_sync_q[1:0], bus.I_DAT_IOB[l]};
      dline_q    <= {dline_q[MAX_DELAY-2:0], ref_sync_q[2]};
      iob_dly_q  <= iob_sync_q[2];
    end

    // Tap 0 already carries one register of delay, matching the extra IOB stage.
    assign mism = dline_q[delay_q] ^ iob_dly_q;

    // Next-state logic: hunt/shift/lock sequencing, counters, error stretch and sticky flags.
    always_comb begin
      logic [EW-1:0] err_nxt;
      logic [OW-1:0] ok_nxt;
      logic          err_hit;
      logic          ok_hit;

      state_d  = state_q;
      delay_d  = delay_q;
      err_d    = err_q;
      ok_d     = ok_q;
      nolock_d = nolock_q;
      ecnt_d   = ecnt_q;
      hold_d   = hold_q;

      err_nxt = err_q;
      ok_nxt  = ok_q;
      if (mism) begin
        if (err_q != EW'(ERROR_COUNT)) err_nxt = err_q + EW'(1);
        ok_nxt = '0;
      end else begin
        if (ok_q != OW'(LOCK_COUNT)) ok_nxt = ok_q + OW'(1);
      end
      err_hit = mism && (err_nxt == EW'(ERROR_COUNT));
      ok_hit  = !mism && (ok_nxt == OW'(LOCK_COUNT));

      case (state_q)
        HUNT: begin
          err_d = err_nxt;
          ok_d  = ok_nxt;
          // Too many errors at this tap wins over lock.
          if (err_hit) begin
            state_d = SHIFT;
          end else if (ok_hit) begin
            state_d  = LOCKED;
            err_d    = '0;
            ok_d     = '0;
            nolock_d = 1'b0;
          end
        end
        SHIFT: begin
          // Single-cycle tap step; the compare result of this cycle is discarded.
          state_d = HUNT;
          delay_d = delay_q + DW'(1);
          err_d   = '0;
          ok_d    = '0;
          if (delay_q == DW'(MAX_DELAY - 1)) nolock_d = 1'b1;
        end
        LOCKED: begin
          err_d = err_nxt;
          ok_d  = ok_nxt;
          if (err_hit) begin
            // Lost lock: re-hunt from the same tap.
            state_d = HUNT;
            err_d   = '0;
            ok_d    = '0;
          end else if (ok_hit) begin
            // A long clean run forgives earlier sporadic errors.
            err_d = '0;
            ok_d  = '0;
          end
          if (mism && (ecnt_q != 16'hFFFF)) ecnt_d = ecnt_q + 16'd1;
        end
        default: state_d = HUNT;
      endcase

      // Retriggerable stretch so short bursts remain visible to slow observers.
      if (mism) begin
        hold_d = HW'(ERROR_HOLD);
      end else if (hold_q != '0) begin
        hold_d = hold_q - HW'(1);
      end

      // Clear overrides any same-cycle increment or sticky set.
      if (bus.I_CLR) begin
        ecnt_d   = '0;
        nolock_d = 1'b0;
      end
    end

    // Lane state registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        state_q  <= HUNT;
        delay_q  <= '0;
        err_q    <= '0;
        ok_q     <= '0;
        nolock_q <= 1'b0;
        ecnt_q   <= '0;
        hold_q   <= '0;
      end else begin
        state_q  <= state_d;
        delay_q  <= delay_d;
        err_q    <= err_d;
        ok_q     <= ok_d;
        nolock_q <= nolock_d;
        ecnt_q   <= ecnt_d;
        hold_q   <= hold_d;
      end
    end

    assign lane_locked[l] = (state_q == LOCKED);
    assign lane_delay[l]  = delay_q;
    assign lane_error[l]  = (hold_q != '0);
    assign lane_ecnt[l]   = ecnt_q;
    assign lane_nolock[l] = nolock_q;
  end

  // Pack per-lane status onto the output buses, lane i in the i-th field.
  always_comb begin
    bus.O_LOCKED  = '0;
    bus.O_DELAY   = '0;
    bus.O_ERROR   = '0;
    bus.O_ERR_CNT = '0;
    bus.O_NOLOCK  = '0;
    for (int l = 0; l < LANES; l++) begin
      bus.O_LOCKED[l]           = lane_locked[l];
      bus.O_DELAY[l*DW +: DW]   = lane_delay[l];
      bus.O_ERROR[l]            = lane_error[l];
      bus.O_ERR_CNT[l*16 +: 16] = lane_ecnt[l];
      bus.O_NOLOCK[l]           = lane_nolock[l];
    end
  end

endmodule

// File: tb/tb_bitstream_aligner.sv
// Purpose: directed vector table plus hand sequences for error, lock-loss, reset, sweep and saturation corners.
// Latency: checks the 5-cycle error latency and lock assertion one cycle after the last required match.
// Backpressure: none; the streams are driven every cycle.
module tb_bitstream_aligner;
  localparam int LANES = 4;
  localparam int MD    = 8;
  localparam int DW    = 3;
  localparam int EC    = 8;
  localparam int LC    = 64;
  localparam int EH    = 20;
  localparam int DW2   = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst2_n;

  bitstream_aligner_if #(.LANES(LANES), .DW(DW))  bus ();
  bitstream_aligner_if #(.LANES(1),     .DW(DW2)) bus2 ();

  bitstream_aligner #(.LANES(LANES), .MAX_DELAY(MD), .ERROR_COUNT(EC),
                      .LOCK_COUNT(LC), .ERROR_HOLD(EH))
    dut (.CLK(clk), .RST_N(rst_n), .bus(bus));

  bitstream_aligner #(.LANES(1), .MAX_DELAY(32), .ERROR_COUNT(100000),
                      .LOCK_COUNT(16), .ERROR_HOLD(4))
    dut2 (.CLK(clk), .RST_N(rst2_n), .bus(bus2));

  int n_cmp  = 0;
  int n_fail = 0;
  int viol   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stimulus state for the main DUT.
  logic [6:0]       lfsr [LANES];
  logic [15:0]      hist [LANES];
  int               dly  [LANES];
  logic [LANES-1:0] inv_m, const_m, inj_m;

  task automatic drive();
    logic [LANES-1:0] r, iv;
    for (int l = 0; l < LANES; l++) begin
      lfsr[l] = {lfsr[l][5:0], lfsr[l][6] ^ lfsr[l][5]};
      r[l]    = const_m[l] ? 1'b0 : lfsr[l][6];
      hist[l] = {hist[l][14:0], r[l]};
      iv[l]   = hist[l][dly[l]] ^ inv_m[l] ^ const_m[l] ^ inj_m[l];
    end
    bus.I_DAT_REF = r;
    bus.I_DAT_IOB = iv;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
  endtask

  // Stimulus state for the saturation DUT.
  logic [6:0] lfsr2;
  logic       err2;

  task automatic step2();
    @(posedge clk);
    #1;
    lfsr2 = {lfsr2[5:0], lfsr2[6] ^ lfsr2[5]};
    bus2.I_DAT_REF = lfsr2[6];
    bus2.I_DAT_IOB = lfsr2[6] ^ err2;
  endtask

  task automatic wait_delay(input int target, input int budget);
    int cur, nc, n;
    n   = 0;
    cur = int'(bus.O_DELAY[DW-1:0]);
    while (cur != target && n < budget) begin
      step();
      n++;
      nc = int'(bus.O_DELAY[DW-1:0]);
      if (nc != cur && nc != ((cur + 1) % MD)) viol++;
      cur = nc;
    end
    if (cur != target) check("wait_delay_timeout", cur, target);
  endtask

  typedef struct {
    logic [LANES*DW-1:0] dly;
    logic [LANES-1:0]    inv;
    logic [LANES-1:0]    lock;
    logic [LANES-1:0]    nolock;
  } vec_t;

  vec_t vecs [4];

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{dly: {3'd7, 3'd2, 3'd0, 3'd5}, inv: 4'b0000, lock: 4'b1111, nolock: 4'b0000};
    vecs[1] = '{dly: {3'd4, 3'd6, 3'd3, 3'd1}, inv: 4'b0000, lock: 4'b1111, nolock: 4'b0000};
    vecs[2] = '{dly: {3'd5, 3'd5, 3'd5, 3'd5}, inv: 4'b0100, lock: 4'b1011, nolock: 4'b0100};
    vecs[3] = '{dly: {3'd2, 3'd4, 3'd4, 3'd6}, inv: 4'b1001, lock: 4'b0110, nolock: 4'b1001};

    lfsr[0] = 7'h01; lfsr[1] = 7'h15; lfsr[2] = 7'h3A; lfsr[3] = 7'h6C;
    for (int l = 0; l < LANES; l++) begin
      hist[l] = '0;
      dly[l]  = 0;
    end
    inv_m = '0; const_m = '0; inj_m = '0;
    rst_n = 1'b0; rst2_n = 1'b0;
    bus.I_CLR = 1'b0; bus2.I_CLR = 1'b0;
    lfsr2 = 7'h2B; err2 = 1'b0;
    drive();
    bus2.I_DAT_REF = 1'b0;
    bus2.I_DAT_IOB = 1'b0;

    fork
      begin : main_thread
        int n, hi;
        step(); step();
        check("rst_locked", bus.O_LOCKED, 0);
        check("rst_delay",  bus.O_DELAY, 0);
        check("rst_error",  bus.O_ERROR, 0);
        check("rst_errcnt", bus.O_ERR_CNT, 0);
        check("rst_nolock", bus.O_NOLOCK, 0);

        // Vector table: per-lane alignment and sweep outcomes.
        for (int v = 0; v < 4; v++) begin
          rst_n = 1'b0;
          inv_m = vecs[v].inv;
          for (int l = 0; l < LANES; l++) dly[l] = int'(vecs[v].dly[l*DW +: DW]);
          step(); step();
          rst_n = 1'b1;
          repeat (500) step();
          check("vec_locked", bus.O_LOCKED, vecs[v].lock);
          check("vec_nolock", bus.O_NOLOCK, vecs[v].nolock);
          for (int l = 0; l < LANES; l++) begin
            if (vecs[v].lock[l]) begin
              check("vec_delay",  bus.O_DELAY[l*DW +: DW], vecs[v].dly[l*DW +: DW]);
              check("vec_errcnt", bus.O_ERR_CNT[l*16 +: 16], 0);
            end
          end
        end

        // Lock lane 0 at delay 5 for the error sequences.
        rst_n = 1'b0;
        inv_m = '0;
        dly[0] = 5; dly[1] = 0; dly[2] = 2; dly[3] = 7;
        step(); step();
        rst_n = 1'b1;
        repeat (500) step();
        check("pre_locked", bus.O_LOCKED, 4'b1111);

        // Seven isolated errors: lock held, each pulse exactly ERROR_HOLD long.
        for (int k = 0; k < 7; k++) begin
          inj_m[0] = 1'b1;
          step();
          inj_m[0] = 1'b0;
          n = 0;
          while (n < 10) begin
            step();
            n++;
            if (bus.O_ERROR[0]) break;
          end
          check("err_latency", n, 5);
          hi = 1;
          while (hi < 100) begin
            step();
            if (bus.O_ERROR[0]) hi++;
            else break;
          end
          check("err_pulse_len", hi, EH);
          repeat (70) step();
        end
        check("iso_locked",  bus.O_LOCKED[0], 1);
        check("iso_errcnt",  bus.O_ERR_CNT[15:0], 7);
        check("iso_errcnt1", bus.O_ERR_CNT[31:16], 0);
        check("iso_error1",  bus.O_ERROR[1], 0);

        // Eight consecutive errors: lock drops, same tap, relock 64 clean cycles later.
        for (int k = 0; k <= 76; k++) begin
          inj_m[0] = (k < 8);
          step();
          if (k == 11) check("burst_before_drop", bus.O_LOCKED[0], 1);
          if (k == 12) begin
            check("burst_drop",  bus.O_LOCKED[0], 0);
            check("burst_delay", bus.O_DELAY[DW-1:0], 5);
          end
          if (k == 75) check("relock_early", bus.O_LOCKED[0], 0);
          if (k == 76) begin
            check("relock",       bus.O_LOCKED[0], 1);
            check("relock_delay", bus.O_DELAY[DW-1:0], 5);
          end
        end
        check("burst_errcnt", bus.O_ERR_CNT[15:0], 15);
        check("burst_lane3",  bus.O_LOCKED[3], 1);

        // One-cycle reset while locked.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_rst_locked", bus.O_LOCKED, 0);
        check("mid_rst_delay",  bus.O_DELAY, 0);
        check("mid_rst_error",  bus.O_ERROR, 0);
        check("mid_rst_errcnt", bus.O_ERR_CNT, 0);
        check("mid_rst_nolock", bus.O_NOLOCK, 0);
        n = 0;
        while (bus.O_LOCKED != 4'b1111 && n < 600) begin
          step();
          n++;
        end
        check("rst_relock",       bus.O_LOCKED, 4'b1111);
        check("rst_relock_delay", bus.O_DELAY, {3'd7, 3'd2, 3'd0, 3'd5});

        // Never-matching lane 0: full sweep, sticky no-lock flag and clear priority.
        rst_n = 1'b0;
        const_m = 4'b0001;
        step();
        rst_n = 1'b1;
        wait_delay(7, 200);
        check("nolock_before_wrap", bus.O_NOLOCK[0], 0);
        wait_delay(0, 40);
        check("nolock_at_wrap", bus.O_NOLOCK[0], 1);
        bus.I_CLR = 1'b1;
        step();
        bus.I_CLR = 1'b0;
        check("nolock_clr", bus.O_NOLOCK[0], 0);
        wait_delay(7, 200);
        bus.I_CLR = 1'b1;
        wait_delay(0, 40);
        check("clr_beats_set", bus.O_NOLOCK[0], 0);
        bus.I_CLR = 1'b0;
        wait_delay(2, 60);
        check("sweep_continues", bus.O_NOLOCK[0], 0);
        check("sweep_order", viol, 0);
        check("sweep_errcnt", bus.O_ERR_CNT[15:0], 0);
        check("sweep_others_locked", bus.O_LOCKED[3:1], 3'b111);
        check("sweep_others_nolock", bus.O_NOLOCK[3:1], 3'b000);
        const_m = '0;
      end
      begin : sat_thread
        int n;
        step2(); step2();
        rst2_n = 1'b1;
        n = 0;
        while (!bus2.O_LOCKED[0] && n < 200) begin
          step2();
          n++;
        end
        check("sat_locked", bus2.O_LOCKED[0], 1);
        check("sat_delay",  bus2.O_DELAY, 0);
        err2 = 1'b1;
        repeat (65600) step2();
        check("sat_errcnt", bus2.O_ERR_CNT, 16'hFFFF);
        check("sat_still_locked", bus2.O_LOCKED[0], 1);
        check("sat_error", bus2.O_ERROR[0], 1);
        bus2.I_CLR = 1'b1;
        step2();
        check("sat_clr_priority", bus2.O_ERR_CNT, 0);
        bus2.I_CLR = 1'b0;
        step2();
        check("sat_after_clr", bus2.O_ERR_CNT, 1);
      end
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
